dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 195 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a valid/ready request channel and
// a valid/ready response channel. One request at a time, fixed access
// latency of WAIT_STATES + 1 cycles, faulted requests answered in one cycle.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_word_addr,
    output logic [1:0]  rsp_width,
    output logic        rsp_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter preload; WAIT_STATES == 0 never enters WAIT, so 0 is a safe filler.
    localparam int         WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WS_INIT = 4'(WS_M1);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                wr_q, wr_d;
    logic [1:0]          width_q, width_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];

    logic                idle;
    logic                cur_wr;
    logic [1:0]          cur_width;
    logic [AW-1:0]       cur_addr;
    logic [31:0]         cur_wdata;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [31:0]         rd_word;
    logic                fault_in;
    logic                commit;
    logic                mem_we;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;

    // An access is illegal for bad width, misalignment or an address beyond the array.
    function automatic logic is_fault(input logic [1:0] w, input logic [31:0] a);
        logic bad;
        bad = (w == 2'b11)
            || (w == 2'b01 && a[0])
            || (w == 2'b10 && a[1:0] != 2'b00)
            || ((a >> AW) != 32'd0);
        return bad;
    endfunction

    // In IDLE the access (for WAIT_STATES == 0) uses the live request; otherwise the latched one.
    assign idle      = (state_q == S_IDLE);
    assign cur_wr    = idle ? req_write            : wr_q;
    assign cur_width = idle ? req_width            : width_q;
    assign cur_addr  = idle ? req_addr[AW-1:0]     : addr_q;
    assign cur_wdata = idle ? req_wdata            : wdata_q;
    assign cur_idx   = cur_addr[AW-1:2];
    assign rd_word   = mem[cur_idx];
    assign fault_in  = is_fault(req_width, req_addr);

    // The memory is touched only on the edge that enters RESP with a legal request.
    assign commit = (idle && req_valid && !fault_in && (WAIT_STATES == 0))
                 || (state_q == S_WAIT && cnt_q == 4'd0);
    assign mem_we = rst_n && commit && cur_wr;

    // Store lane enables and replicated store data.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = cur_wdata;
        case (cur_width)
            2'b00: begin
                be        = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << cur_addr[1:0];
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = cur_wdata;
            end
        endcase
    end

    // Next-state, request capture and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_d    = wr_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    width_d = req_width;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    if (fault_in) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = req_write ? 32'd0 : rd_word;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'd0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request and response data; outputs are masked while not valid, so no reset is needed.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        width_q <= width_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign req_ready     = idle;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_rdata     = rsp_valid ? rdata_q      : 32'd0;
    assign rsp_word_addr = rsp_valid ? addr_q[1:0]  : 2'd0;
    assign rsp_width     = rsp_valid ? width_q      : 2'd0;
    assign rsp_error     = rsp_valid ? err_q        : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=3 instance driven by a scoreboarded
// random/directed stream, plus a WAIT_STATES=0 instance for back-to-back timing.
module tb_dmem_responder;

    localparam int DL2 = 10;
    localparam int WS  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_word_addr, rsp_width;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [1:0]  z_req_width;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_error;
    logic        z_rsp_ready = 1'b1;
    logic [31:0] z_rsp_rdata;
    logic [1:0]  z_rsp_word_addr, z_rsp_width;

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_word_addr(rsp_word_addr), .rsp_width(rsp_width), .rsp_error(rsp_error)
    );

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_width(z_req_width), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_word_addr(z_rsp_word_addr), .rsp_width(z_rsp_width), .rsp_error(z_rsp_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  wa;
        logic [1:0]  wd;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [7:0] mb [128];
    bit mon_on   = 1'b0;
    bit force_bp = 1'b0;
    bit fresh    = 1'b1;
    bit exp_next = 1'b0;
    int bp_left  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic bit model_fault(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'b11) return 1'b1;
        if (w == 2'b01 && (a % 2) != 0) return 1'b1;
        if (w == 2'b10 && (a % 4) != 0) return 1'b1;
        if (a >= (32'd4 << DL2)) return 1'b1;
        return 1'b0;
    endfunction

    // Waits for an idle responder, presents one request, records its expectation.
    task automatic issue(input logic wr, input logic [1:0] wd, input logic [31:0] a,
                         input logic [31:0] d, input bit track);
        exp_t e;
        int guard = 0;
        int n;
        @(negedge clk);
        while (req_ready !== 1'b1) begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_width = 2'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            guard++;
            if (guard > 200) begin
                $display("FAIL req_ready_timeout: got %0h want 1", req_ready);
                $fatal(1, "responder stuck");
            end
            @(negedge clk);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_width = wd;
        req_addr  = a;
        req_wdata = d;
        if (track) begin
            e.acc   = cyc;
            e.wa    = a[1:0];
            e.wd    = wd;
            e.rdata = 32'd0;
            if (model_fault(wd, a)) begin
                e.err = 1'b1;
                e.lat = 1;
            end else begin
                e.err = 1'b0;
                e.lat = WS + 1;
                n = (wd == 2'b00) ? 1 : (wd == 2'b01) ? 2 : 4;
                if (wr) begin
                    for (int i = 0; i < n; i++) mb[int'(a[6:0]) + i] = d[8*i +: 8];
                end else begin
                    for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = mb[int'({a[6:2], 2'b00}) + i];
                end
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Response monitor: compares every presented response with the scoreboard head.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_on) begin
                fresh    = 1'b1;
                exp_next = 1'b0;
                bp_left  = 0;
            end else begin
                if (exp_next) begin
                    chk("req_ready_after_handshake", req_ready, 1);
                    exp_next = 1'b0;
                end
                if (rsp_valid) begin
                    chk("req_ready_while_busy", req_ready, 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
                        rsp_ready = 1'b1;
                    end else begin
                        mon_e = sbq[0];
                        if (fresh) begin
                            chk("latency", cyc - mon_e.acc, mon_e.lat);
                            if (force_bp) begin
                                bp_left  = 5;
                                force_bp = 1'b0;
                            end
                        end
                        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                        chk("rsp_word_addr", rsp_word_addr, mon_e.wa);
                        chk("rsp_width", rsp_width, mon_e.wd);
                        chk("rsp_error", rsp_error, mon_e.err);
                        fresh = 1'b0;
                        if (bp_left > 0) begin
                            rsp_ready = 1'b0;
                            bp_left--;
                        end else begin
                            rsp_ready = ($urandom_range(0, 3) != 0);
                        end
                        if (rsp_ready) begin
                            void'(sbq.pop_front());
                            fresh    = 1'b1;
                            exp_next = 1'b1;
                        end
                    end
                end else begin
                    chk("rsp_zero_when_idle", {rsp_rdata, rsp_word_addr, rsp_width, rsp_error}, 0);
                    rsp_ready = 1'($urandom);
                end
            end
        end
    end

    logic [31:0] zval [4];
    int          zidx, zlast, zpend;
    logic [31:0] a_r;
    int          guard;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0; req_write   = 1'b0; req_width   = 2'b00;
        req_addr    = 32'd0; req_wdata  = 32'd0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_width = 2'b10;
        z_req_addr  = 32'd0; z_req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_fields", {rsp_rdata, rsp_word_addr, rsp_width, rsp_error}, 0);
        chk("reset_ws0_req_ready", z_req_ready, 1);
        rst_n = 1'b1;

        // Zero-wait instance: 4 word stores then 4 loads, offered every cycle.
        for (int k = 0; k < 4; k++) zval[k] = $urandom;
        zidx  = 0;
        zlast = -1;
        zpend = -1;
        for (int t = 0; t < 40 && (zidx < 8 || zpend >= 0); t++) begin
            @(negedge clk);
            if (zpend >= 0) begin
                chk("ws0_rsp_valid", z_rsp_valid, 1);
                chk("ws0_rsp_rdata", z_rsp_rdata, (zpend < 4) ? 32'd0 : zval[7 - zpend]);
                chk("ws0_rsp_error", z_rsp_error, 0);
                chk("ws0_req_ready_busy", z_req_ready, 0);
                zpend = -1;
            end else begin
                chk("ws0_rsp_idle", z_rsp_valid, 0);
            end
            if (z_req_ready && zidx < 8) begin
                if (zlast >= 0) chk("ws0_interval", cyc - zlast, 2);
                zlast       = cyc;
                z_req_valid = 1'b1;
                z_req_width = 2'b10;
                z_req_write = (zidx < 4);
                z_req_addr  = (zidx < 4) ? 32'(zidx * 4) : 32'((7 - zidx) * 4);
                z_req_wdata = (zidx < 4) ? zval[zidx] : 32'hFFFF_FFFF;
                zpend       = zidx;
                zidx++;
            end else if (zidx >= 8) begin
                z_req_valid = 1'b0;
            end
        end
        chk("ws0_all_accepted", zidx, 8);
        z_req_valid = 1'b0;

        mon_on = 1'b1;
        for (int k = 0; k < 32; k++) issue(1'b1, 2'b10, 32'(k * 4), 32'd0, 1'b1);

        // Word store then load.
        issue(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 2'b10, 32'h10, 32'd0, 1'b1);

        // Byte and half lanes.
        issue(1'b1, 2'b10, 32'h20, 32'd0, 1'b1);
        issue(1'b1, 2'b00, 32'h21, 32'h0000_00AA, 1'b1);
        issue(1'b1, 2'b01, 32'h22, 32'h0000_1234, 1'b1);
        issue(1'b0, 2'b10, 32'h20, 32'd0, 1'b1);
        issue(1'b0, 2'b00, 32'h21, 32'd0, 1'b1);

        // Faults, then show the touched words are intact.
        issue(1'b1, 2'b01, 32'h3, 32'h0000_FFFF, 1'b1);
        issue(1'b0, 2'b10, 32'h6, 32'd0, 1'b1);
        issue(1'b1, 2'b11, 32'h8, 32'h5555_5555, 1'b1);
        issue(1'b0, 2'b10, 32'h0000_1000, 32'd0, 1'b1);
        issue(1'b1, 2'b10, 32'h0000_1004, 32'h7777_7777, 1'b1);
        issue(1'b0, 2'b10, 32'h0, 32'd0, 1'b1);
        issue(1'b0, 2'b10, 32'h4, 32'd0, 1'b1);
        issue(1'b0, 2'b10, 32'h8, 32'd0, 1'b1);

        // Five cycles of backpressure on a load.
        force_bp = 1'b1;
        issue(1'b0, 2'b10, 32'h10, 32'd0, 1'b1);

        // Reset while a store sits in WAIT: it must be dropped.
        issue(1'b1, 2'b10, 32'h40, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_rsp_valid", rsp_valid, 0);
        chk("midop_reset_req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 2'b10, 32'h40, 32'd0, 1'b1);

        // Randomized mix, including misaligned and out-of-range accesses.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0)
                a_r = $urandom | (32'd1 << (12 + $urandom_range(0, 19)));
            else
                a_r = 32'($urandom_range(0, 127));
            issue(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  a_r, $urandom, 1'b1);
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
